// File: rtl/uart_rx_pkg.sv
// Shared UART receive definitions: divider defaults and FSM encoding.
package uart_rx_pkg;

  localparam int         DIV_WID_DEF = 9;
  localparam logic [8:0] DIV_CNT_DEF = 9'd433;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_e;

  function automatic logic timed_state(input rx_state_e s);
    return (s == START) || (s == DATA) || (s == STOP);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the async serial line plus falling-edge detect.
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q,
  output logic o_fall
);

  logic meta;
  logic rx_q;

  // Reset to 1 so an idle line never looks like a start edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta <= 1'b1;
      o_q  <= 1'b1;
      rx_q <= 1'b1;
    end else begin
      meta <= i_d;
      o_q  <= meta;
      rx_q <= o_q;
    end
  end

  assign o_fall = rx_q & ~o_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int                 DIV_WID = DIV_WID_DEF,
  parameter logic [DIV_WID-1:0] DIV_CNT = DIV_WID'(DIV_CNT_DEF)
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_uart_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam logic [DIV_WID-1:0] HALF_CNT = DIV_CNT >> 1;

  rx_state_e          state;
  logic [DIV_WID-1:0] div;
  logic [2:0]         bit_cnt;
  logic [7:0]         shift;
  logic               rx_s;
  logic               fall;
  logic               tick;

  uart_rx_sync u_sync (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_d    (i_uart_rx),
    .o_q    (rx_s),
    .o_fall (fall)
  );

  assign tick   = timed_state(state) && (div == '0);
  assign o_busy = (state != IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      div         <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      if (timed_state(state))
        div <= tick ? DIV_CNT : div - 1'b1;
      unique case (state)
        IDLE: begin
          if (fall) begin
            state <= START;
            div   <= HALF_CNT;
          end
        end
        START: begin
          if (tick) begin
            if (!rx_s) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        DATA: begin
          if (tick) begin
            shift   <= {rx_s, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7)
              state <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            if (rx_s) begin
              o_data  <= shift;
              o_valid <= 1'b1;
              state   <= IDLE;
            end else begin
              o_frame_err <= 1'b1;
              state       <= BREAK;
            end
          end
        end
        BREAK: begin
          // A held-low line must go high before a new start is armed.
          if (rx_s)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed and random frames against a queue-based receive model.
module tb_uart_rx;

  localparam int P   = 16;
  localparam int LAT = 3 + (P - 1) / 2 + 1 + 9 * P;

  typedef struct {
    logic [7:0] d;
    int         t;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       rx2 = 1'b1;
  logic [7:0] data, data2;
  logic       valid, ferr, busy;
  logic       valid2, ferr2, busy2;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_valid = 0;
  int n_ferr  = 0;
  int n_v2    = 0;
  int n_f2    = 0;
  logic [7:0] got2 = 8'h00;
  logic [7:0] last_data = 8'h00;
  logic       rst_seen = 1'b1;
  exp_t       exp_q[$];
  int         ferr_q[$];

  uart_rx #(.DIV_WID(4), .DIV_CNT(4'd15)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_uart_rx   (rx),
    .o_data      (data),
    .o_valid     (valid),
    .o_frame_err (ferr),
    .o_busy      (busy)
  );

  uart_rx u_def (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_uart_rx   (rx2),
    .o_data      (data2),
    .o_valid     (valid2),
    .o_frame_err (ferr2),
    .o_busy      (busy2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    rst_seen <= rst;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_seen) begin
      exp_q.delete();
      ferr_q.delete();
      last_data = 8'h00;
      chk("rst_valid", {31'd0, valid}, 0);
      chk("rst_ferr", {31'd0, ferr}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_data", {24'd0, data}, 0);
    end else begin
      chk("excl", {31'd0, valid & ferr}, 0);
      if (valid) begin
        n_valid++;
        chk("valid_expected", {31'd0, exp_q.size() != 0}, 1);
        if (exp_q.size() != 0) begin
          chk("data", {24'd0, data}, {24'd0, exp_q[0].d});
          chk("latency", cyc - exp_q[0].t, LAT);
          last_data = exp_q[0].d;
          void'(exp_q.pop_front());
        end
      end else begin
        chk("hold", {24'd0, data}, {24'd0, last_data});
      end
      if (ferr) begin
        n_ferr++;
        chk("ferr_expected", {31'd0, ferr_q.size() != 0}, 1);
        if (ferr_q.size() != 0) begin
          chk("ferr_latency", cyc - ferr_q[0], LAT);
          void'(ferr_q.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && valid2) begin
      n_v2++;
      got2 = data2;
    end
    if (!rst && ferr2)
      n_f2++;
  end

  // Caller is positioned at a negedge; returns at a negedge, line high.
  task automatic send(input logic [7:0] b, input logic stop, input int p);
    exp_t e;
    rx = 1'b0;
    if (stop) begin
      e.d = b;
      e.t = cyc;
      exp_q.push_back(e);
    end else begin
      ferr_q.push_back(cyc);
    end
    repeat (p) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (p) @(negedge clk);
    end
    rx = stop;
    repeat (p) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send2(input logic [7:0] b, input int p);
    rx2 = 1'b0;
    repeat (p) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx2 = b[i];
      repeat (p) @(negedge clk);
    end
    rx2 = 1'b1;
    repeat (p) @(negedge clk);
  endtask

  initial begin
    int n0, f0, v0;
    logic [7:0] rb;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 1: two clean frames
    n0 = n_valid;
    f0 = n_ferr;
    send(8'h55, 1'b1, P);
    send(8'hA3, 1'b1, P);
    repeat (10) @(negedge clk);
    chk("t1_count", n_valid - n0, 2);
    chk("t1_noferr", n_ferr - f0, 0);

    // 2: short glitch
    n0 = n_valid;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    chk("t2_busy_hi", {31'd0, busy}, 1);
    repeat (20) @(negedge clk);
    chk("t2_busy_lo", {31'd0, busy}, 0);
    chk("t2_novalid", n_valid - n0, 0);
    chk("t2_noferr", n_ferr - f0, 0);

    // 3: framing error, break, then a good frame
    n0 = n_valid;
    send(8'h3C, 1'b0, P);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    chk("t3_break_busy", {31'd0, busy}, 1);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("t3_ferr", n_ferr - f0, 1);
    chk("t3_busy_lo", {31'd0, busy}, 0);
    chk("t3_data_kept", {24'd0, data}, 32'h0000_00A3);
    send(8'h81, 1'b1, P);
    repeat (5) @(negedge clk);
    chk("t3_valid", n_valid - n0, 1);
    chk("t3_data", {24'd0, data}, 32'h0000_0081);

    // 4: back-to-back frames
    n0 = n_valid;
    send(8'h00, 1'b1, P);
    send(8'hFF, 1'b1, P);
    send(8'h00, 1'b1, P);
    repeat (5) @(negedge clk);
    chk("t4_count", n_valid - n0, 3);

    // 5: reset during data bit 4
    n0 = n_valid;
    fork
      send(8'hF0, 1'b1, P);
      begin
        repeat (5 * P + 5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    join
    repeat (10) @(negedge clk);
    chk("t5_aborted", n_valid - n0, 0);
    chk("t5_data_rst", {24'd0, data}, 0);
    send(8'h5A, 1'b1, P);
    repeat (5) @(negedge clk);
    chk("t5_valid", n_valid - n0, 1);
    chk("t5_data", {24'd0, data}, 32'h0000_005A);

    // random frames, random gaps
    n0 = n_valid;
    for (int i = 0; i < 8; i++) begin
      rb = 8'($urandom);
      send(rb, 1'b1, P);
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    repeat (5) @(negedge clk);
    chk("rand_count", n_valid - n0, 8);

    // 6: default divider with +/-3% bit period
    v0 = n_v2;
    send2(8'hC6, 421);
    chk("t6_fast_valid", n_v2 - v0, 1);
    chk("t6_fast_data", {24'd0, got2}, 32'h0000_00C6);
    repeat (20) @(negedge clk);
    send2(8'hC6, 447);
    chk("t6_slow_valid", n_v2 - v0, 2);
    chk("t6_slow_data", {24'd0, got2}, 32'h0000_00C6);
    chk("t6_noferr", n_f2, 0);
    repeat (5) @(negedge clk);
    chk("t6_idle", {31'd0, busy2}, 0);

    chk("exp_q_empty", exp_q.size(), 0);
    chk("ferr_q_empty", ferr_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
